// File: rtl/cntr_pkg.sv
// Shared definitions for the arbitrated counter bank: opcodes, FSM states
// and default geometry.
package cntr_pkg;
   localparam int DEF_NUM_REQ  = 4;
   localparam int DEF_NUM_LANE = 8;
   localparam int DEF_LANE_W   = 4;

   typedef enum logic [1:0] {
      OP_INC  = 2'b00,
      OP_DEC  = 2'b01,
      OP_LOAD = 2'b10,
      OP_CLR  = 2'b11
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;
endpackage

// File: rtl/cntr_bank_arb_if.sv
// Requester-side command bus and bank status for cntr_bank_arb.
// master = requester group / bench, slave = the arbitrated bank.
interface cntr_bank_arb_if
   import cntr_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int NUM_LANE = DEF_NUM_LANE,
   parameter int LANE_W   = DEF_LANE_W
);
   localparam int LSEL_W = $clog2(NUM_LANE);

   logic [NUM_REQ-1:0]         req;
   logic [2*NUM_REQ-1:0]       op;
   logic [LSEL_W*NUM_REQ-1:0]  lane_sel;
   logic [LANE_W*NUM_REQ-1:0]  load_val;
   logic [NUM_REQ-1:0]         gnt;
   logic                       busy;
   logic [NUM_LANE-1:0]        wrap;
   logic [NUM_LANE*LANE_W-1:0] data_out;

   modport master (
      output req, op, lane_sel, load_val,
      input  gnt, busy, wrap, data_out
   );

   modport slave (
      input  req, op, lane_sel, load_val,
      output gnt, busy, wrap, data_out
   );
endinterface

// File: rtl/cntr_bank_arb_rr_arb.sv
// Round-robin arbiter: the search starts one past the last granted
// requester; the pointer moves only when advance_i accepts a winner.
module rr_arb #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_i,
   input  logic         advance_i,
   output logic [N-1:0] winner_o
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] start_q;
   logic [PW-1:0] start_d;
   logic          found;
   int            idx;
   int            win_idx;

   always_comb begin
      winner_o = '0;
      found    = 1'b0;
      idx      = 0;
      win_idx  = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(start_q) + i) % N;
         if (!found && req_i[idx]) begin
            winner_o[idx] = 1'b1;
            win_idx       = idx;
            found         = 1'b1;
         end
      end
      start_d = PW'((win_idx + 1) % N);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q <= '0;
      end else if (advance_i && found) begin
         start_q <= start_d;
      end
   end
endmodule

// File: rtl/cntr_bank_arb.sv
// Arbitrated bank of wrap-around up/down counters: one command accepted in
// IDLE, executed on the lane at the edge that ends EXEC.
module cntr_bank_arb
   import cntr_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int NUM_LANE = DEF_NUM_LANE,
   parameter int LANE_W   = DEF_LANE_W
) (
   input logic             clk,
   input logic             reset,
   cntr_bank_arb_if.slave  bus
);
   localparam int LSEL_W = $clog2(NUM_LANE);

   state_e                          state_q;
   logic [NUM_REQ-1:0]              gnt_q;
   logic                            busy_q;
   logic [NUM_LANE-1:0]             wrap_q;
   logic [NUM_LANE-1:0][LANE_W-1:0] lanes_q;
   op_e                             op_q;
   logic [LSEL_W-1:0]               lane_q;
   logic [LANE_W-1:0]               val_q;

   logic [NUM_REQ-1:0] winner;
   logic               accept;
   op_e                op_d;
   logic [LSEL_W-1:0]  lane_d;
   logic [LANE_W-1:0]  val_d;

   assign accept = (state_q == ST_IDLE) && (|bus.req);

   rr_arb #(.N(NUM_REQ)) u_arb (
      .clk       (clk),
      .rst       (reset),
      .req_i     (bus.req),
      .advance_i (accept),
      .winner_o  (winner)
   );

   always_comb begin
      op_d   = OP_INC;
      lane_d = '0;
      val_d  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) begin
            op_d   = op_e'(bus.op[2*i +: 2]);
            lane_d = bus.lane_sel[LSEL_W*i +: LSEL_W];
            val_d  = bus.load_val[LANE_W*i +: LANE_W];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         wrap_q  <= '0;
         lanes_q <= '0;
         op_q    <= OP_INC;
         lane_q  <= '0;
         val_q   <= '0;
      end else begin
         wrap_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  gnt_q   <= winner;
                  busy_q  <= 1'b1;
                  op_q    <= op_d;
                  lane_q  <= lane_d;
                  val_q   <= val_d;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
               // wrap is flagged from the pre-update value so it lands with the new count
               case (op_q)
                  OP_INC: begin
                     lanes_q[lane_q] <= lanes_q[lane_q] + LANE_W'(1);
                     wrap_q[lane_q]  <= (lanes_q[lane_q] == '1);
                  end
                  OP_DEC: begin
                     lanes_q[lane_q] <= lanes_q[lane_q] - LANE_W'(1);
                     wrap_q[lane_q]  <= (lanes_q[lane_q] == '0);
                  end
                  OP_LOAD: lanes_q[lane_q] <= val_q;
                  OP_CLR:  lanes_q[lane_q] <= '0;
                  default: lanes_q[lane_q] <= lanes_q[lane_q];
               endcase
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.busy     = busy_q;
   assign bus.wrap     = wrap_q;
   assign bus.data_out = lanes_q;
endmodule
